// File: rtl/snd_mix.sv
// snd_mix: two-channel (BGM + SE) volume mixer with saturation and a 16-bit
// I2S transmitter. It runs on SND_MCLK with 256 clocks per frame and
// BCLK = SND_MCLK/4.
// Ports: SND_MCLK/SND_RSTN clock and sync active-low reset; ENABLE and
//   VOL_BGM/VOL_SE are sampled at frame start; UNDERRUN is a sticky flag,
//   cleared by UNDERRUN_CLR; FIFO_RD_x/FIFO_VALID_x/FIFO_DOUT_x connect to the
//   sound FIFOs; I2S_BCLK/I2S_LRCK/I2S_SDATA go to the codec pins.
// Build option: SND_MIX_SE_EN enables the SE channel. Without it, only BGM
//   is mixed and the SE inputs are ignored.
module snd_mix #(
    parameter int VOL_SHIFT = 7
) (
    input  logic        SND_MCLK,
    input  logic        SND_RSTN,
    input  logic        ENABLE,
    input  logic [7:0]  VOL_BGM,
    input  logic [7:0]  VOL_SE,
    input  logic        UNDERRUN_CLR,
    output logic        UNDERRUN,
    output logic        FIFO_RD_BGM,
    output logic        FIFO_RD_SE,
    input  logic        FIFO_VALID_BGM,
    input  logic        FIFO_VALID_SE,
    input  logic [31:0] FIFO_DOUT_BGM,
    input  logic [31:0] FIFO_DOUT_SE,
    output logic        I2S_BCLK,
    output logic        I2S_LRCK,
    output logic        I2S_SDATA
);

`ifdef SND_MIX_SE_EN
    localparam logic SE_ON = 1'b1;
    logic        w_se_vld;
    logic [31:0] w_se_dat;
    logic [7:0]  w_se_vol;
    assign w_se_vld = FIFO_VALID_SE;
    assign w_se_dat = FIFO_DOUT_SE;
    assign w_se_vol = VOL_SE;
`else
    localparam logic SE_ON = 1'b0;
    logic        w_se_vld;
    logic [31:0] w_se_dat;
    logic [7:0]  w_se_vol;
    logic        w_unused_se;
    assign w_se_vld = 1'b0;
    assign w_se_dat = 32'h0;
    assign w_se_vol = 8'h0;
    assign w_unused_se = &{1'b0, FIFO_VALID_SE, FIFO_DOUT_SE, VOL_SE};
`endif

    logic [7:0]         r_cnt;
    logic               r_en;
    logic [7:0]         r_vol_b, r_vol_s;
    logic               r_got_b, r_got_s;
    logic [31:0]        r_smp_b, r_smp_s;
    logic               r_rd_b, r_rd_s;
    logic               r_ur;
    logic signed [24:0] r_p_bl, r_p_br, r_p_sl, r_p_sr;
    logic [15:0]        r_mix_l, r_mix_r;
    logic [15:0]        r_sh_l, r_sh_r;
    logic               r_bclk, r_lrck, r_sdata;

    logic [5:0]         w_slot;
    logic               w_bit_edge;
    logic               w_win;
    logic               w_miss;
    logic signed [24:0] w_pbl, w_pbr, w_psl, w_psr;
    logic signed [18:0] w_sum_l, w_sum_r;

    assign w_slot     = r_cnt[7:2];
    assign w_bit_edge = (r_cnt[1:0] == 2'd0);
    assign w_win      = (r_cnt >= 8'd1) && (r_cnt <= 8'd3);

    // Last chance to see VALID is cnt==3, so this cycle's VALID counts too.
    assign w_miss = r_en
                  & ((~r_got_b & ~FIFO_VALID_BGM)
                  | (SE_ON & ~r_got_s & ~w_se_vld));

    // 16b signed sample times 9b non-negative volume gives a 25b product.
    assign w_pbl = $signed(r_smp_b[31:16]) * $signed({1'b0, r_vol_b});
    assign w_pbr = $signed(r_smp_b[15:0])  * $signed({1'b0, r_vol_b});
    assign w_psl = $signed(r_smp_s[31:16]) * $signed({1'b0, r_vol_s});
    assign w_psr = $signed(r_smp_s[15:0])  * $signed({1'b0, r_vol_s});

    // Shifted products fit in 18 bits, so a 19-bit sum cannot overflow.
    assign w_sum_l = 19'(r_p_bl) + 19'(r_p_sl);
    assign w_sum_r = 19'(r_p_br) + 19'(r_p_sr);

    function automatic logic [15:0] sat16(input logic signed [18:0] v);
        if (v > 19'sd32767)
            return 16'h7FFF;
        else if (v < -19'sd32768)
            return 16'h8000;
        else
            return 16'(v);
    endfunction

    always_ff @(posedge SND_MCLK) begin
        if (!SND_RSTN) begin
            r_cnt   <= 8'd0;
            r_en    <= 1'b0;
            r_vol_b <= 8'd0;
            r_vol_s <= 8'd0;
            r_got_b <= 1'b0;
            r_got_s <= 1'b0;
            r_smp_b <= 32'd0;
            r_smp_s <= 32'd0;
            r_rd_b  <= 1'b0;
            r_rd_s  <= 1'b0;
        end else begin
            r_cnt  <= r_cnt + 8'd1;
            r_rd_b <= 1'b0;
            r_rd_s <= 1'b0;
            if (r_cnt == 8'd0) begin
                r_en    <= ENABLE;
                r_vol_b <= VOL_BGM;
                r_vol_s <= w_se_vol;
                r_got_b <= 1'b0;
                r_got_s <= 1'b0;
                r_smp_b <= 32'd0;
                r_smp_s <= 32'd0;
                r_rd_b  <= ENABLE;
                r_rd_s  <= ENABLE & SE_ON;
            end
            if (w_win && r_en) begin
                if (FIFO_VALID_BGM && !r_got_b) begin
                    r_smp_b <= FIFO_DOUT_BGM;
                    r_got_b <= 1'b1;
                end
                if (w_se_vld && !r_got_s) begin
                    r_smp_s <= w_se_dat;
                    r_got_s <= 1'b1;
                end
            end
        end
    end

    always_ff @(posedge SND_MCLK) begin
        if (!SND_RSTN) begin
            r_ur <= 1'b0;
        end else if (UNDERRUN_CLR) begin
            r_ur <= 1'b0;
        end else if (r_cnt == 8'd3 && w_miss) begin
            r_ur <= 1'b1;
        end
    end

    always_ff @(posedge SND_MCLK) begin
        if (!SND_RSTN) begin
            r_p_bl  <= '0;
            r_p_br  <= '0;
            r_p_sl  <= '0;
            r_p_sr  <= '0;
            r_mix_l <= 16'd0;
            r_mix_r <= 16'd0;
        end else begin
            if (r_cnt == 8'd4) begin
                r_p_bl <= w_pbl >>> VOL_SHIFT;
                r_p_br <= w_pbr >>> VOL_SHIFT;
                r_p_sl <= w_psl >>> VOL_SHIFT;
                r_p_sr <= w_psr >>> VOL_SHIFT;
            end
            if (r_cnt == 8'd5) begin
                r_mix_l <= sat16(w_sum_l);
                r_mix_r <= sat16(w_sum_r);
            end
        end
    end

    // Data and LRCK update on the clock that drives BCLK low.
    always_ff @(posedge SND_MCLK) begin
        if (!SND_RSTN) begin
            r_sh_l  <= 16'd0;
            r_sh_r  <= 16'd0;
            r_bclk  <= 1'b0;
            r_lrck  <= 1'b0;
            r_sdata <= 1'b0;
        end else begin
            r_bclk <= r_cnt[1];
            if (r_cnt == 8'd255) begin
                r_sh_l <= r_mix_l;
                r_sh_r <= r_mix_r;
            end
            if (w_bit_edge) begin
                r_lrck <= (w_slot >= 6'd31) && (w_slot != 6'd63);
                if (w_slot < 6'd16) begin
                    r_sdata <= r_sh_l[15];
                    r_sh_l  <= {r_sh_l[14:0], 1'b0};
                end else if (w_slot >= 6'd32 && w_slot < 6'd48) begin
                    r_sdata <= r_sh_r[15];
                    r_sh_r  <= {r_sh_r[14:0], 1'b0};
                end else begin
                    r_sdata <= 1'b0;
                end
            end
        end
    end

    assign UNDERRUN    = r_ur;
    assign FIFO_RD_BGM = r_rd_b;
    assign FIFO_RD_SE  = r_rd_s;
    assign I2S_BCLK    = r_bclk;
    assign I2S_LRCK    = r_lrck;
    assign I2S_SDATA   = r_sdata;

endmodule

// File: tb/tb_snd_mix.sv
// tb_snd_mix: frame-level bench for snd_mix. Expected stereo words go into a
// queue per frame; an I2S monitor deserializes each frame and compares.
module tb_snd_mix;

`ifdef SND_MIX_SE_EN
    localparam bit SE = 1'b1;
`else
    localparam bit SE = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rstn;
    logic        en;
    logic [7:0]  vol_b, vol_s;
    logic        ur_clr;
    logic        ur;
    logic        rd_b, rd_s;
    logic        vld_b = 1'b0;
    logic        vld_s = 1'b0;
    logic [31:0] dat_b, dat_s;
    logic        bclk, lrck, sdata;
    bit          have_b, have_s;

    int checks = 0;
    int errors = 0;

    logic [31:0] q[$];

    always #5 clk = ~clk;

    snd_mix dut (
        .SND_MCLK      (clk),
        .SND_RSTN      (rstn),
        .ENABLE        (en),
        .VOL_BGM       (vol_b),
        .VOL_SE        (vol_s),
        .UNDERRUN_CLR  (ur_clr),
        .UNDERRUN      (ur),
        .FIFO_RD_BGM   (rd_b),
        .FIFO_RD_SE    (rd_s),
        .FIFO_VALID_BGM(vld_b),
        .FIFO_VALID_SE (vld_s),
        .FIFO_DOUT_BGM (dat_b),
        .FIFO_DOUT_SE  (dat_s),
        .I2S_BCLK      (bclk),
        .I2S_LRCK      (lrck),
        .I2S_SDATA     (sdata)
    );

    // FIFO model: VALID one cycle after a pop, only if it holds data.
    always @(posedge clk) begin
        vld_b <= rd_b && have_b;
        vld_s <= rd_s && have_s;
    end

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // I2S monitor: shift in a bit on every BCLK rise; an LRCK fall marks
    // slot 63, closing the frame.
    bit          mon_en = 1'b0;
    logic        pb, plr;
    logic [63:0] sd, lr;
    int          nbits;

    always @(negedge clk) begin
        if (!mon_en) begin
            pb    = 1'b0;
            plr   = 1'b0;
            nbits = 0;
        end else begin
            if (bclk && !pb) begin
                sd = {sd[62:0], sdata};
                lr = {lr[62:0], lrck};
                nbits++;
                if (!lrck && plr) begin
                    checks++;
                    if (nbits != 64 || lr !== 64'h0000_0001_FFFF_FFFE) begin
                        errors++;
                        $display("FAIL framing lrck=%h nbits=%0d required lrck=%h nbits=64",
                                 lr, nbits, 64'h0000_0001_FFFF_FFFE);
                    end
                    if (q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL sdata frame with no expected entry actual=%h",
                                 {sd[63:48], sd[31:16]});
                    end else begin
                        chk("sdata", {sd[63:48], sd[31:16]}, q.pop_front());
                        chk("pad", {sd[47:32], sd[15:0]}, 32'h0);
                    end
                    nbits = 0;
                end
                plr = lrck;
            end
            pb = bclk;
        end
    end

    typedef struct {
        bit          en;
        logic [7:0]  vb, vs;
        logic [31:0] bgm, se;
        bit          hb, hs, clr;
        bit          ur_se, ur_no;
        logic [31:0] exp_se, exp_no;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input bit e, input logic [7:0] vb, input logic [7:0] vs,
                       input logic [31:0] bgm, input logic [31:0] se,
                       input bit hb, input bit hs, input bit clr,
                       input bit urs, input bit urn,
                       input logic [31:0] xs, input logic [31:0] xn);
        vec_t v;
        v.en = e; v.vb = vb; v.vs = vs; v.bgm = bgm; v.se = se;
        v.hb = hb; v.hs = hs; v.clr = clr;
        v.ur_se = urs; v.ur_no = urn;
        v.exp_se = xs; v.exp_no = xn;
        vecs.push_back(v);
    endtask

    // Called at the negedge just before the frame's cnt==0 edge.
    task automatic run_frame(input vec_t v);
        int nb, ns;
        en     = v.en;
        vol_b  = v.vb;
        vol_s  = v.vs;
        dat_b  = v.bgm;
        dat_s  = v.se;
        have_b = v.hb;
        have_s = v.hs;
        q.push_back(SE ? v.exp_se : v.exp_no);
        nb = 0;
        ns = 0;
        for (int j = 0; j < 256; j++) begin
            @(posedge clk);
            @(negedge clk);
            if (rd_b) nb++;
            if (rd_s) ns++;
            if (j == 2) ur_clr = v.clr;
            if (j == 3) ur_clr = 1'b0;
            if (j == 10) chk("underrun", 32'(ur), 32'(SE ? v.ur_se : v.ur_no));
        end
        chk("rd_bgm_count", nb, 32'(v.en));
        chk("rd_se_count", ns, 32'(v.en && SE));
    endtask

    initial begin
        logic [7:0] bpat;
        rstn   = 1'b0;
        en     = 1'b1;
        vol_b  = 8'd128;
        vol_s  = 8'd128;
        ur_clr = 1'b0;
        dat_b  = 32'h0;
        dat_s  = 32'h0;
        have_b = 1'b0;
        have_s = 1'b1;
        bpat   = 8'h0;

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_outputs", {26'd0, ur, rd_b, rd_s, bclk, lrck, sdata}, 32'h0);
        rstn = 1'b1;
        for (int j = 0; j < 99; j++) begin
            @(posedge clk);
            @(negedge clk);
            if (j < 8) bpat[j] = bclk;
            if (j == 0) chk("rd_at_cnt0", {30'd0, rd_b, rd_s}, {30'd0, 1'b1, SE});
            if (j == 1) chk("rd_one_cycle", {30'd0, rd_b, rd_s}, 32'h0);
            if (j == 10) chk("underrun_bgm_empty", 32'(ur), 32'h1);
            if (j == 98) chk("bclk_before_reset", 32'(bclk), 32'h1);
        end
        chk("bclk_pattern", 32'(bpat), 32'hCC);

        // Mid-frame reset at cnt==99.
        rstn = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk("midframe_reset", {26'd0, ur, rd_b, rd_s, bclk, lrck, sdata}, 32'h0);
        @(posedge clk);
        @(negedge clk);

        add(1, 128, 128, 32'h7FFF_8000, 32'h0,         1, 1, 0, 0, 0, 32'h7FFF_8000, 32'h7FFF_8000);
        add(1, 128, 128, 32'h4000_C000, 32'h4000_C000, 1, 1, 0, 0, 0, 32'h7FFF_8000, 32'h4000_C000);
        add(1,  64,  64, 32'h4000_C000, 32'h4000_C000, 1, 1, 0, 0, 0, 32'h4000_C000, 32'h2000_E000);
        add(1, 255, 128, 32'h0100_0100, 32'h0,         1, 1, 0, 0, 0, 32'h01FE_01FE, 32'h01FE_01FE);
        add(1, 128, 128, 32'h7FFF_8000, 32'h7FFF_8000, 1, 1, 0, 0, 0, 32'h7FFF_8000, 32'h7FFF_8000);
        add(1, 255, 128, 32'h7FFF_C000, 32'h0,         1, 1, 0, 0, 0, 32'h7FFF_8080, 32'h7FFF_8080);
        add(1,   1, 128, 32'h0000_FFFF, 32'h0,         1, 1, 0, 0, 0, 32'h0000_FFFF, 32'h0000_FFFF);
        add(1, 128, 128, 32'h1234_5678, 32'h7FFF_7FFF, 1, 0, 0, 1, 0, 32'h1234_5678, 32'h1234_5678);
        add(1, 128, 128, 32'h1234_5678, 32'h7FFF_7FFF, 1, 0, 1, 0, 0, 32'h1234_5678, 32'h1234_5678);
        add(1, 128, 128, 32'h1234_5678, 32'h7FFF_7FFF, 1, 0, 0, 1, 0, 32'h1234_5678, 32'h1234_5678);
        add(1, 128, 128, 32'h1234_5678, 32'h0,         1, 1, 1, 0, 0, 32'h1234_5678, 32'h1234_5678);
        add(1, 128, 128, 32'h5555_5555, 32'h0010_0010, 0, 1, 0, 1, 1, 32'h0010_0010, 32'h0);
        add(0, 128, 128, 32'h1234_5678, 32'h1234_5678, 1, 1, 1, 0, 0, 32'h0,         32'h0);
        add(0, 128, 128, 32'h1234_5678, 32'h1234_5678, 1, 1, 0, 0, 0, 32'h0,         32'h0);
        add(0, 128, 128, 32'h1234_5678, 32'h1234_5678, 1, 1, 0, 0, 0, 32'h0,         32'h0);
        add(0, 128, 128, 32'h1234_5678, 32'h1234_5678, 1, 1, 0, 0, 0, 32'h0,         32'h0);

        rstn   = 1'b1;
        mon_en = 1'b1;
        q.delete();
        q.push_back(32'h0);
        foreach (vecs[i]) run_frame(vecs[i]);

        // The last frame's sample is still queued for the next frame.
        chk("queue_leftover", q.size(), 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
